// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// A shadow register holds the digit codes and decimal points, so the display
// never tears while the datapath changes value. One digit is lit at a time,
// with a short all-off gap between digits to suppress ghosting. The scan
// position is visible on digit_idx and an.
//
// Output timing: every output is registered from the *next* scan state and the
// *current* shadow contents. A load at edge k therefore shows up on sseg/dp at
// edge k+1 if that digit is lit. blank and lz_blank are sampled live.
module sseg_scan_driver #(
    parameter int N_DIGITS     = 4,
    parameter int DIV_COUNT    = 50000,
    parameter int BLANK_CYCLES = 2,
    parameter int HEX_EN       = 1,
    localparam int IDX_W       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic                  load,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  lz_blank,
    input  logic                  blank,
    output logic [0:6]            sseg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]      digit_idx
);

    // Prescaler counts 0..DIV_COUNT-1 while lit and 0..BLANK_CYCLES-1 in the gap.
    localparam int MAX_CNT = (DIV_COUNT > BLANK_CYCLES) ? DIV_COUNT : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] LIT_LAST = CNT_W'(DIV_COUNT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    localparam logic [0:6] SEG_OFF = 7'b1111111;

    typedef enum logic {
        ST_GAP = 1'b0,  // all anodes off between digits
        ST_LIT = 1'b1   // anode of digit_idx driven low
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [IDX_W-1:0]      idx_d;

    logic [4*N_DIGITS-1:0] shadow_val;
    logic [N_DIGITS-1:0]   shadow_dp;

    logic [3:0]            nib [N_DIGITS];
    logic [N_DIGITS-1:0]   lz_zero;
    logic                  zero_run;

    logic [3:0]            code_sel;
    logic [0:6]            seg_lit;
    logic                  dp_lit;
    logic [N_DIGITS-1:0]   an_lit;

    // Active-low hex decoder; codes above 9 go dark in decimal-only builds.
    function automatic logic [0:6] decode(input logic [3:0] code);
        logic [0:6] seg;
        case (code)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        if (HEX_EN == 0 && code > 4'd9) begin
            seg = SEG_OFF;
        end
        return seg;
    endfunction

    // Capture value and decimal points only on load; the scan reads nothing else.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
        end else if (load) begin
            shadow_val <= value;
            shadow_dp  <= dp_in;
        end
    end

    // Split the shadow word into per-digit nibbles.
    for (genvar g = 0; g < N_DIGITS; g++) begin : g_nib
        assign nib[g] = shadow_val[4*g +: 4];
    end

    // lz_zero[i]: digit i and every more significant digit are zero.
    // Digit 0 is never flagged so a zero value still shows a single "0".
    always_comb begin
        lz_zero  = '0;
        zero_run = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run & (nib[i] == 4'd0);
            lz_zero[i] = zero_run;
        end
    end

    // Scan sequencing: gap for BLANK_CYCLES, lit for DIV_COUNT, then next digit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = digit_idx;
        case (state_q)
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_LIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_q == LIT_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                    idx_d   = (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
                end
            end
        endcase
    end

    // Segment, dp and anode pattern for the digit that will be selected next.
    always_comb begin
        code_sel = nib[idx_d];
        if (lz_blank && lz_zero[idx_d]) begin
            seg_lit = SEG_OFF;
        end else begin
            seg_lit = decode(code_sel);
        end
        dp_lit = ~shadow_dp[idx_d];
        an_lit = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (IDX_W'(i) == idx_d) begin
                an_lit[i] = 1'b0;
            end
        end
    end

    // Scan FSM with registered pin outputs; reset restarts the scan at digit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_GAP;
            cnt_q     <= '0;
            digit_idx <= '0;
            an        <= '1;
            sseg      <= SEG_OFF;
            dp        <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            digit_idx <= idx_d;
            if (state_d == ST_LIT) begin
                an   <= an_lit;
                sseg <= blank ? SEG_OFF : seg_lit;
                dp   <= blank ? 1'b1 : dp_lit;
            end else begin
                an   <= '1;
                sseg <= SEG_OFF;
                dp   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver with N_DIGITS=4, DIV_COUNT=4, BLANK_CYCLES=1.
// A hex instance and a decimal-only instance share all inputs.
module tb_sseg_scan_driver;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp_in;
    logic        lz_blank;
    logic        blank;

    logic [0:6]  sseg,  sseg2;
    logic        dp,    dp2;
    logic [3:0]  an,    an2;
    logic [1:0]  idx,   idx2;

    sseg_scan_driver #(
        .N_DIGITS(4), .DIV_COUNT(4), .BLANK_CYCLES(1), .HEX_EN(1)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .dp_in(dp_in),
        .lz_blank(lz_blank), .blank(blank),
        .sseg(sseg), .dp(dp), .an(an), .digit_idx(idx)
    );

    sseg_scan_driver #(
        .N_DIGITS(4), .DIV_COUNT(4), .BLANK_CYCLES(1), .HEX_EN(0)
    ) dut_dec (
        .clk(clk), .rst(rst), .value(value), .load(load), .dp_in(dp_in),
        .lz_blank(lz_blank), .blank(blank),
        .sseg(sseg2), .dp(dp2), .an(an2), .digit_idx(idx2)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp_in;
        logic        lz;
        logic        sel;    // 0: hex instance, 1: decimal-only instance
        int          digit;
        logic [0:6]  sseg;
        logic        dp;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [15:0] v, input logic [3:0] d, input logic lz,
                           input logic sel, input int dig, input logic [0:6] s,
                           input logic p);
        vec_t r;
        r.value = v; r.dp_in = d; r.lz = lz; r.sel = sel;
        r.digit = dig; r.sseg = s; r.dp = p;
        vecs.push_back(r);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp_in = d;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    // Advance until the chosen instance shows the requested anode pattern.
    task automatic wait_an(input logic [3:0] target, input logic sel, input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if ((sel ? an2 : an) === target) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, an=%b required %b", name, sel ? an2 : an, target);
        end
    endtask

    function automatic logic [3:0] lit_pattern(input int d);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << d);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t required < 100000", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0] exp_an;
        logic [1:0] exp_idx;

        rst = 1'b1; value = '0; load = 1'b0; dp_in = '0; lz_blank = 1'b0; blank = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_an", an, 4'b1111);
        check("rst_sseg", sseg, 7'b1111111);
        check("rst_dp", dp, 1'b1);
        check("rst_idx", idx, 2'd0);
        check("rst_an_dec", an2, 4'b1111);

        // Scan timing after release: 1 gap clock, 4 lit clocks per digit
        rst = 1'b0;
        for (int j = 1; j <= 21; j++) begin
            tick();
            exp_idx = 2'((j / 5) % 4);
            exp_an  = (j % 5 == 0) ? 4'b1111 : lit_pattern((j / 5) % 4);
            check($sformatf("scan_an_%0d", j), an, exp_an);
            check($sformatf("scan_idx_%0d", j), idx, exp_idx);
        end

        // Decode / dp / leading-zero vectors
        add_vec(16'h12AF, 4'b0100, 1'b0, 1'b0, 0, 7'b0111000, 1'b1);
        add_vec(16'h12AF, 4'b0100, 1'b0, 1'b0, 1, 7'b0001000, 1'b1);
        add_vec(16'h12AF, 4'b0100, 1'b0, 1'b0, 2, 7'b0010010, 1'b0);
        add_vec(16'h12AF, 4'b0100, 1'b0, 1'b0, 3, 7'b1001111, 1'b1);
        add_vec(16'h3456, 4'b0000, 1'b0, 1'b0, 0, 7'b0100000, 1'b1);
        add_vec(16'h3456, 4'b0000, 1'b0, 1'b0, 1, 7'b0100100, 1'b1);
        add_vec(16'h3456, 4'b0000, 1'b0, 1'b0, 2, 7'b1001100, 1'b1);
        add_vec(16'h3456, 4'b0000, 1'b0, 1'b0, 3, 7'b0000110, 1'b1);
        add_vec(16'h789C, 4'b0001, 1'b0, 1'b0, 0, 7'b0110001, 1'b0);
        add_vec(16'h789C, 4'b0001, 1'b0, 1'b0, 1, 7'b0000100, 1'b1);
        add_vec(16'h789C, 4'b0001, 1'b0, 1'b0, 2, 7'b0000000, 1'b1);
        add_vec(16'h789C, 4'b0001, 1'b0, 1'b0, 3, 7'b0001111, 1'b1);
        add_vec(16'hEBD0, 4'b0000, 1'b0, 1'b0, 0, 7'b0000001, 1'b1);
        add_vec(16'hEBD0, 4'b0000, 1'b0, 1'b0, 1, 7'b1000010, 1'b1);
        add_vec(16'hEBD0, 4'b0000, 1'b0, 1'b0, 2, 7'b1100000, 1'b1);
        add_vec(16'hEBD0, 4'b0000, 1'b0, 1'b0, 3, 7'b0110000, 1'b1);
        add_vec(16'h0070, 4'b0000, 1'b1, 1'b0, 3, 7'b1111111, 1'b1);
        add_vec(16'h0070, 4'b0000, 1'b1, 1'b0, 2, 7'b1111111, 1'b1);
        add_vec(16'h0070, 4'b0000, 1'b1, 1'b0, 1, 7'b0001111, 1'b1);
        add_vec(16'h0070, 4'b0000, 1'b1, 1'b0, 0, 7'b0000001, 1'b1);
        add_vec(16'h0070, 4'b1000, 1'b1, 1'b0, 3, 7'b1111111, 1'b0);
        add_vec(16'h0000, 4'b0000, 1'b1, 1'b0, 0, 7'b0000001, 1'b1);
        add_vec(16'h0000, 4'b0000, 1'b1, 1'b0, 1, 7'b1111111, 1'b1);
        add_vec(16'h0000, 4'b0000, 1'b1, 1'b0, 3, 7'b1111111, 1'b1);
        add_vec(16'h0000, 4'b0000, 1'b0, 1'b0, 2, 7'b0000001, 1'b1);
        add_vec(16'h0100, 4'b0000, 1'b1, 1'b0, 3, 7'b1111111, 1'b1);
        add_vec(16'h0100, 4'b0000, 1'b1, 1'b0, 2, 7'b1001111, 1'b1);
        add_vec(16'h0100, 4'b0000, 1'b1, 1'b0, 1, 7'b0000001, 1'b1);
        add_vec(16'h00B9, 4'b0000, 1'b0, 1'b1, 1, 7'b1111111, 1'b1);
        add_vec(16'h00B9, 4'b0000, 1'b0, 1'b1, 0, 7'b0000100, 1'b1);
        add_vec(16'h00B9, 4'b0000, 1'b0, 1'b0, 1, 7'b1100000, 1'b1);

        for (int v = 0; v < vecs.size(); v++) begin
            lz_blank = vecs[v].lz;
            pulse_load(vecs[v].value, vecs[v].dp_in);
            wait_an(lit_pattern(vecs[v].digit), vecs[v].sel, $sformatf("vec%0d_wait", v));
            check($sformatf("vec%0d_sseg", v), vecs[v].sel ? sseg2 : sseg, vecs[v].sseg);
            check($sformatf("vec%0d_dp", v), vecs[v].sel ? dp2 : dp, vecs[v].dp);
        end

        // No tearing: value changes without load do not reach the display
        lz_blank = 1'b0;
        pulse_load(16'h12AF, 4'b0100);
        wait_an(4'b1110, 1'b0, "tear_wait0");
        check("tear_before", sseg, 7'b0111000);
        value = 16'h5555;
        wait_an(4'b1101, 1'b0, "tear_wait1");
        check("tear_d1", sseg, 7'b0001000);
        wait_an(4'b1110, 1'b0, "tear_wait2");
        check("tear_d0", sseg, 7'b0111000);

        // Load while digit 2 is lit: old code at the load edge, new one at the next
        wait_an(4'b1011, 1'b0, "midload_wait");
        value = 16'h18AF;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        check("midload_an_k", an, 4'b1011);
        check("midload_sseg_k", sseg, 7'b0010010);
        tick();
        check("midload_an_k1", an, 4'b1011);
        check("midload_sseg_k1", sseg, 7'b0000000);

        // Reset mid-scan
        wait_an(4'b1011, 1'b0, "midrst_wait");
        rst = 1'b1;
        tick();
        check("midrst_an", an, 4'b1111);
        check("midrst_sseg", sseg, 7'b1111111);
        check("midrst_dp", dp, 1'b1);
        check("midrst_idx", idx, 2'd0);

        // blank: segments and dp dark while the anodes keep walking
        rst   = 1'b0;
        blank = 1'b1;
        value = 16'h12AF;
        dp_in = 4'b1111;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        check("blank_an_1", an, 4'b1110);
        check("blank_sseg_1", sseg, 7'b1111111);
        check("blank_dp_1", dp, 1'b1);
        for (int j = 2; j <= 6; j++) begin
            tick();
            exp_an = (j % 5 == 0) ? 4'b1111 : lit_pattern(j / 5);
            check($sformatf("blank_an_%0d", j), an, exp_an);
            check($sformatf("blank_sseg_%0d", j), sseg, 7'b1111111);
            check($sformatf("blank_dp_%0d", j), dp, 1'b1);
        end
        blank = 1'b0;
        tick();
        check("unblank_an", an, 4'b1101);
        check("unblank_sseg", sseg, 7'b0001000);
        check("unblank_dp", dp, 1'b0);

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
